// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions for the program-counter unit: default geometry,
// reset vector and the per-edge command decode.
package pc_unit_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_RESET_VECTOR = 0;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_RET,
    CMD_CALL,
    CMD_JUMP,
    CMD_BRANCH,
    CMD_INC
  } cmd_e;

  // Only the highest-priority active command acts; reset is handled by the registers.
  function automatic cmd_e decode_cmd(input logic stall, input logic ret,
                                      input logic call, input logic jump,
                                      input logic branch);
    if (stall)       return CMD_HOLD;
    else if (ret)    return CMD_RET;
    else if (call)   return CMD_CALL;
    else if (jump)   return CMD_JUMP;
    else if (branch) return CMD_BRANCH;
    else             return CMD_INC;
  endfunction

endpackage

// File: rtl/pc_unit_register_w.sv
// Single-bit flop with synchronous reset, and a WIDTH-bit enabled register
// assembled from those flops plus a hold/load mux.
module dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end
endmodule

module register_w #(
  parameter int              W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] d_next;

  assign d_next = en ? d : q;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    dff #(.RST_VAL(RST_VAL[gi])) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (d_next[gi]),
      .q   (q[gi])
    );
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump, relative branch and a LIFO return
// stack for call/ret; overflow and underflow raise a sticky err flag.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               DEPTH        = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  cmd_e             cmd;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [PTR_W:0]   depth_reg;
  logic             err_reg;
  logic             push_ok;
  logic             pop_ok;
  logic             set_err;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [WIDTH-1:0] entry_q [DEPTH];

  assign stack_full  = (depth_reg == FULL_CNT);
  assign stack_empty = (depth_reg == '0);
  assign err         = err_reg;
  assign pc_inc      = pc + WIDTH'(1);
  assign wr_idx      = depth_reg[PTR_W-1:0];
  // DEPTH is a power of two, so the top-of-stack index wraps cleanly.
  assign rd_idx      = wr_idx - PTR_W'(1);
  assign cmd         = decode_cmd(stall, ret, call, jump, branch);

  always_comb begin
    pc_next = pc_inc;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    set_err = 1'b0;
    case (cmd)
      CMD_HOLD: pc_next = pc;
      CMD_RET: begin
        if (!stack_empty) begin
          pc_next = entry_q[rd_idx];
          pop_ok  = 1'b1;
        end else begin
          set_err = 1'b1;
        end
      end
      CMD_CALL: begin
        if (!stack_full) begin
          pc_next = target;
          push_ok = 1'b1;
        end else begin
          set_err = 1'b1;
        end
      end
      CMD_JUMP:   pc_next = target;
      // Same-width add is the sign-extended displacement modulo 2^WIDTH.
      CMD_BRANCH: pc_next = pc + offset;
      default:    pc_next = pc_inc;
    endcase
  end

  register_w #(.W(WIDTH), .RST_VAL(RESET_VECTOR)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (!stall),
    .d   (pc_next),
    .q   (pc)
  );

  // Entries are never cleared: depth_reg alone decides what is readable.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    register_w #(.W(WIDTH), .RST_VAL('0)) u_entry (
      .clk (clk),
      .rst (1'b0),
      .en  (push_ok && (wr_idx == PTR_W'(gi))),
      .d   (pc_inc),
      .q   (entry_q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (push_ok)     depth_reg <= depth_reg + 1'b1;
      else if (pop_ok) depth_reg <= depth_reg - 1'b1;
      if (set_err)     err_reg   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table for the documented sequences,
// then randomized commands against a queue-based reference model.
module tb_pc_unit;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, stall, jump, branch, call, ret;
  logic [W-1:0] target, offset;
  logic [W-1:0] pc;
  logic         stack_full, stack_empty, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .offset      (offset),
    .pc          (pc),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
  );

  typedef struct {
    logic         rst, stall, jump, branch, call, ret;
    logic [W-1:0] target, offset;
    logic [W-1:0] exp_pc;
    logic         exp_full, exp_empty, exp_err;
  } vec_t;

  vec_t vecs [$];

  // Reference model: a queue is the return stack.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack [$];
  logic         m_err;

  function automatic vec_t mk(input logic r, s, j, b, c, rt,
                              input logic [W-1:0] t, o, epc,
                              input logic ef, ee, er);
    vec_t v;
    v.rst = r; v.stall = s; v.jump = j; v.branch = b; v.call = c; v.ret = rt;
    v.target = t; v.offset = o; v.exp_pc = epc;
    v.exp_full = ef; v.exp_empty = ee; v.exp_err = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = v.stall; jump = v.jump; branch = v.branch;
    call = v.call; ret = v.ret; target = v.target; offset = v.offset;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] epc,
                       input logic ef, ee, er);
    checks++;
    if (pc !== epc || stack_full !== ef || stack_empty !== ee || err !== er) begin
      failures++;
      $display("FAIL %s: got pc=%02h full=%b empty=%b err=%b, want pc=%02h full=%b empty=%b err=%b",
               name, pc, stack_full, stack_empty, err, epc, ef, ee, er);
    end else begin
      $display("ok   %s: pc=%02h full=%b empty=%b err=%b", name, pc, stack_full, stack_empty, err);
    end
  endtask

  task automatic model_step(input vec_t v);
    if (v.rst) begin
      m_pc = 8'h00; m_stack.delete(); m_err = 1'b0;
    end else if (v.stall) begin
      // everything holds
    end else if (v.ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_err = 1'b1; m_pc = m_pc + 8'd1; end
    end else if (v.call) begin
      if (m_stack.size() < D) begin m_stack.push_back(m_pc + 8'd1); m_pc = v.target; end
      else begin m_err = 1'b1; m_pc = m_pc + 8'd1; end
    end else if (v.jump)   m_pc = v.target;
    else if (v.branch)     m_pc = m_pc + v.offset;
    else                   m_pc = m_pc + 8'd1;
  endtask

  initial begin
    rst = 1; stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
    target = '0; offset = '0;

    //          rst s j b c r  target offset  pc   full empty err
    vecs.push_back(mk(1,0,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0)); // reset
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h01, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h02, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h03, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h04, 0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 8'h05,8'h00, 8'h05, 0,1,0)); // jump 05
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00,8'hFD, 8'h02, 0,1,0)); // branch -3
    vecs.push_back(mk(0,0,1,0,0,0, 8'hFF,8'h00, 8'hFF, 0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0)); // wrap
    vecs.push_back(mk(0,0,1,0,0,0, 8'h10,8'h00, 8'h10, 0,1,0));
    vecs.push_back(mk(0,0,0,0,1,0, 8'h40,8'h00, 8'h40, 0,0,0)); // call 40
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h41, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h00,8'h00, 8'h42, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h11, 0,1,0)); // ret
    vecs.push_back(mk(0,0,0,0,1,0, 8'h20,8'h00, 8'h20, 0,0,0)); // push 12
    vecs.push_back(mk(0,0,0,0,1,0, 8'h30,8'h00, 8'h30, 0,0,0)); // push 21
    vecs.push_back(mk(0,0,0,0,1,0, 8'h50,8'h00, 8'h50, 0,0,0)); // push 31
    vecs.push_back(mk(0,0,0,0,1,0, 8'h60,8'h00, 8'h60, 1,0,0)); // push 51, full
    vecs.push_back(mk(0,0,0,0,1,0, 8'h70,8'h00, 8'h61, 1,0,1)); // overflow
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h51, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h31, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h21, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h12, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h13, 0,1,1)); // underflow
    vecs.push_back(mk(0,1,1,0,0,0, 8'h80,8'h00, 8'h13, 0,1,1)); // stall+jump
    vecs.push_back(mk(1,0,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0));
    vecs.push_back(mk(0,0,0,0,1,0, 8'h40,8'h00, 8'h40, 0,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 8'h90,8'h00, 8'h00, 0,1,0)); // rst+call
    vecs.push_back(mk(0,0,0,0,0,1, 8'h00,8'h00, 8'h01, 0,1,1)); // stack discarded
    vecs.push_back(mk(1,0,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0));
    vecs.push_back(mk(0,0,0,0,1,0, 8'h22,8'h00, 8'h22, 0,0,0)); // push 01
    vecs.push_back(mk(0,0,1,0,1,1, 8'h99,8'h00, 8'h01, 0,1,0)); // ret wins
    vecs.push_back(mk(0,0,1,1,0,0, 8'h44,8'h05, 8'h44, 0,1,0)); // jump beats branch
    vecs.push_back(mk(0,0,0,1,0,0, 8'h00,8'h05, 8'h49, 0,1,0)); // branch +5
    vecs.push_back(mk(1,1,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0)); // rst beats stall

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_full,
            vecs[i].exp_empty, vecs[i].exp_err);
    end

    begin
      vec_t v;
      v = mk(1,0,0,0,0,0, 8'h00,8'h00, 8'h00, 0,1,0);
      model_step(v);
      drive(v);
      check("rnd_reset", m_pc, m_stack.size() == D, m_stack.size() == 0, m_err);
      for (int n = 0; n < 400; n++) begin
        v.rst    = ($urandom_range(0, 49) == 0);
        v.stall  = ($urandom_range(0, 7) == 0);
        v.jump   = ($urandom_range(0, 3) == 0);
        v.branch = ($urandom_range(0, 3) == 0);
        v.call   = ($urandom_range(0, 2) == 0);
        v.ret    = ($urandom_range(0, 2) == 0);
        v.target = W'($urandom);
        v.offset = W'($urandom);
        model_step(v);
        drive(v);
        check($sformatf("rnd%0d", n), m_pc, m_stack.size() == D,
              m_stack.size() == 0, m_err);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
